// File: rtl/ili9341_tx_sched.sv
// ili9341_tx_sched: FIFO-buffered D/C+byte scheduler with CS framing and handshake watchdog
module ili9341_tx_sched #(
  parameter int DEPTH    = 16,
  parameter int CS_SETUP = 1,
  parameter int CS_HOLD  = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     wr_dc,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     send,
  output logic [7:0]               tx_byte,
  output logic                     tx_dc,
  input  logic                     spi_done,
  output logic                     cs_n,
  output logic                     busy,
  output logic                     overflow,
  output logic                     timeout_err,
  input  logic                     err_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int M1 = TIMEOUT > CS_HOLD ? TIMEOUT : CS_HOLD;
  localparam int CMAX = M1 > CS_SETUP ? M1 : CS_SETUP;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] SET_L = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_L = CW'(CS_HOLD);
  localparam logic [CW-1:0] TO_L = CW'(TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, SETUP, ISSUE, WAIT, HOLD} state_t;
  state_t state, state_n;
  logic [8:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic push, pop, to_fire;
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  assign push = wr_en & ~full;
  assign send = state == ISSUE;
  assign busy = state != IDLE;
  // next state; pops happen only on entry into ISSUE
  always_comb begin
    state_n = state;
    pop = 1'b0;
    to_fire = 1'b0;
    case (state)
      IDLE:  state_n = empty ? IDLE : SETUP;
      SETUP: if (cnt == SET_L) begin state_n = ISSUE; pop = 1'b1; end
      ISSUE: state_n = WAIT;
      WAIT:
        if (spi_done) begin
          state_n = empty ? HOLD : ISSUE;
          pop = ~empty;
        end else if (cnt == TO_L) begin
          state_n = IDLE;
          to_fire = 1'b1;
        end
      HOLD:
        if (!empty) begin
          state_n = ISSUE;
          pop = 1'b1;
        end else if (cnt == HOLD_L) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // FIFO storage needs no reset; emptiness is tracked by level
  always_ff @(posedge clk)
    if (push) mem[wp] <= {wr_dc, wr_data};
  // state, counter, pointers, outputs and sticky errors
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      wp <= '0;
      rp <= '0;
      level <= '0;
      cs_n <= 1'b1;
      tx_byte <= 8'h00;
      tx_dc <= 1'b0;
      overflow <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= (state_n != state) ? '0 : cnt + 1'b1;
      cs_n <= state_n == IDLE;
      wp <= push ? wp + 1'b1 : wp;
      rp <= pop ? rp + 1'b1 : rp;
      level <= level + LW'(push) - LW'(pop);
      {tx_dc, tx_byte} <= pop ? mem[rp] : {tx_dc, tx_byte};
      overflow <= err_clr ? 1'b0 : overflow | (wr_en & full);
      timeout_err <= err_clr ? 1'b0 : timeout_err | to_fire;
    end
  end
endmodule

// File: tb/tb_ili9341_tx_sched.sv
// tb_ili9341_tx_sched: directed table-driven bench for the ILI9341 byte scheduler
module tb_ili9341_tx_sched;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic wr_en = 1'b0, wr_dc = 1'b0, spi_done = 1'b0, err_clr = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic full, empty, send, tx_dc, cs_n, busy, overflow, timeout_err;
  logic [4:0] level;
  logic [7:0] tx_byte;
  int checks = 0;
  int errors = 0;

  ili9341_tx_sched dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_dc(wr_dc), .wr_data(wr_data),
    .full(full), .empty(empty), .level(level), .send(send), .tx_byte(tx_byte),
    .tx_dc(tx_dc), .spi_done(spi_done), .cs_n(cs_n), .busy(busy),
    .overflow(overflow), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       dc;
    logic [7:0] data;
    int         dly;
    logic [7:0] exp_byte;
    logic       exp_dc;
  } vec_t;
  vec_t v[4];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic dc, input logic [7:0] d);
    wr_en = 1'b1;
    wr_dc = dc;
    wr_data = d;
    tick;
    wr_en = 1'b0;
  endtask

  task automatic done_pulse;
    spi_done = 1'b1;
    tick;
    spi_done = 1'b0;
  endtask

  logic [7:0] bexp [6];
  logic [7:0] dexp [16];

  initial begin
    v[0] = '{1'b0, 8'h2A, 0, 8'h2A, 1'b0};
    v[1] = '{1'b1, 8'h55, 1, 8'h55, 1'b1};
    v[2] = '{1'b0, 8'hFF, 10, 8'hFF, 1'b0};
    v[3] = '{1'b1, 8'h00, 3, 8'h00, 1'b1};
    bexp = '{8'h2C, 8'hF8, 8'hF9, 8'hFA, 8'hFB, 8'hFC};
    #23;
    chk("rst_send", send, 0);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_busy", busy, 0);
    chk("rst_tx_byte", tx_byte, 8'h00);
    chk("rst_tx_dc", tx_dc, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_timeout", timeout_err, 0);
    tick;
    rst = 1'b1;
    tick;

    // single commands from the table
    for (int i = 0; i < 4; i++) begin
      push(v[i].dc, v[i].data);
      chk("single_level", level, 1);
      chk("single_cs_pre", cs_n, 1);
      tick;
      chk("single_cs_low", cs_n, 0);
      chk("single_busy", busy, 1);
      chk("single_nosend", send, 0);
      tick;
      chk("single_send", send, 1);
      chk("single_byte", tx_byte, v[i].exp_byte);
      chk("single_dc", tx_dc, v[i].exp_dc);
      tick;
      chk("single_send_once", send, 0);
      repeat (v[i].dly) tick;
      done_pulse;
      chk("single_hold_cs", cs_n, 0);
      repeat (4) tick;
      chk("single_hold_end_cs", cs_n, 0);
      tick;
      chk("single_release_cs", cs_n, 1);
      chk("single_idle_busy", busy, 0);
    end

    // burst of one command and five pixel bytes
    push(1'b0, 8'h2C);
    for (int i = 1; i < 6; i++) push(1'b1, 8'hF7 + 8'(i));
    for (int i = 0; i < 6; i++) begin
      chk("burst_byte", tx_byte, bexp[i]);
      chk("burst_dc", tx_dc, i != 0);
      chk("burst_cs", cs_n, 0);
      chk("burst_wait_nosend", send, 0);
      done_pulse;
      chk("burst_b2b_send", send, i < 5);
      tick;
    end
    repeat (3) tick;
    chk("burst_hold_cs", cs_n, 0);
    tick;
    chk("burst_release_cs", cs_n, 1);

    // HOLD re-entry without SETUP
    push(1'b0, 8'h11);
    repeat (3) tick;
    done_pulse;
    tick;
    chk("reent_cs_m1", cs_n, 0);
    push(1'b1, 8'h22);
    chk("reent_cs_m2", cs_n, 0);
    chk("reent_nosend_m2", send, 0);
    tick;
    chk("reent_send", send, 1);
    chk("reent_cs_m3", cs_n, 0);
    chk("reent_byte", tx_byte, 8'h22);
    chk("reent_dc", tx_dc, 1);
    tick;
    done_pulse;
    repeat (5) tick;
    chk("reent_release_cs", cs_n, 1);

    // full / overflow with SPI held busy
    push(1'b0, 8'hA0);
    repeat (3) tick;
    for (int i = 0; i < 16; i++) push(1'b1, 8'hB0 + 8'(i));
    chk("ovf_full", full, 1);
    chk("ovf_level16", level, 16);
    chk("ovf_not_yet", overflow, 0);
    push(1'b1, 8'hC0);
    chk("ovf_level_kept", level, 16);
    chk("ovf_set", overflow, 1);
    wr_en = 1'b1; wr_data = 8'hC1; spi_done = 1'b1;
    tick;
    wr_en = 1'b0; spi_done = 1'b0;
    chk("ovf_pushpop_level", level, 15);
    chk("ovf_pushpop_send", send, 1);
    chk("ovf_pushpop_byte", tx_byte, 8'hB0);
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    chk("ovf_clr", overflow, 0);
    push(1'b1, 8'hD0);
    chk("ovf_refill", full, 1);
    wr_en = 1'b1; err_clr = 1'b1; wr_data = 8'hD1;
    tick;
    wr_en = 1'b0; err_clr = 1'b0;
    chk("ovf_clr_priority", overflow, 0);
    for (int i = 0; i < 15; i++) dexp[i] = 8'hB1 + 8'(i);
    dexp[15] = 8'hD0;
    for (int i = 0; i < 16; i++) begin
      done_pulse;
      chk("ovf_drain_byte", tx_byte, dexp[i]);
      tick;
    end
    chk("ovf_drained", empty, 1);
    done_pulse;
    repeat (5) tick;
    chk("ovf_release_cs", cs_n, 1);

    // watchdog
    push(1'b0, 8'hE1);
    push(1'b1, 8'hE2);
    repeat (65) tick;
    chk("wd_before", timeout_err, 0);
    chk("wd_cs_before", cs_n, 0);
    tick;
    chk("wd_err", timeout_err, 1);
    chk("wd_cs", cs_n, 1);
    chk("wd_busy", busy, 0);
    chk("wd_kept", level, 1);
    done_pulse;
    chk("wd_idle_done_ignored", level, 1);
    chk("wd_setup_cs", cs_n, 0);
    chk("wd_setup_nosend", send, 0);
    tick;
    chk("wd_reissue_send", send, 1);
    chk("wd_reissue_byte", tx_byte, 8'hE2);
    chk("wd_reissue_dc", tx_dc, 1);
    chk("wd_reissue_level", level, 0);

    // async reset mid-WAIT with three entries queued
    tick;
    done_pulse;
    repeat (5) tick;
    for (int i = 0; i < 4; i++) push(1'b1, 8'hF0 + 8'(i));
    chk("rst_pre_level", level, 3);
    chk("rst_pre_cs", cs_n, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_cs", cs_n, 1);
    chk("arst_send", send, 0);
    chk("arst_level", level, 0);
    chk("arst_empty", empty, 1);
    chk("arst_busy", busy, 0);
    chk("arst_tx", tx_byte, 8'h00);
    chk("arst_timeout", timeout_err, 0);
    tick;
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("arst_no_send", send, 0);
    end
    chk("arst_cs_idle", cs_n, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ili9341_tx_sched.md
# ili9341_tx_sched

Byte scheduler sitting directly upstream of the SPI shift controller in the ILI9341 display path. It buffers {D/C, byte} entries from the command/pixel generators in a FIFO. It issues them one at a time to the SPI controller with a one-cycle `send` pulse and holds `tx_byte`/`tx_dc` stable until that controller's `done`. It also owns panel chip-select framing, with programmable setup and hold, and a watchdog on the handshake.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `CS_SETUP`, 1: cycles `cs_n` is low before the first `send` of a burst; ≥ 1.
- `CS_HOLD`, 4: idle cycles `cs_n` stays low after the last `done` before release; ≥ 1.
- `TIMEOUT`, 64: max cycles in WAIT without `done` before error; ≥ 16.
- `clk` input 1: single system clock; all logic on rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `wr_en` input 1: push `{wr_dc, wr_data}` when not full.
- `wr_dc` input 1: 0 = command, 1 = data.
- `wr_data` input 8: byte to send.
- `full` output 1: FIFO holds DEPTH entries.
- `empty` output 1: FIFO holds 0 entries.
- `level` output $clog2(DEPTH)+1: current occupancy.
- `send` output 1: one-cycle request to the SPI controller.
- `tx_byte` output 8: byte presented to the SPI controller.
- `tx_dc` output 1: D/C line to the panel, aligned with `tx_byte`.
- `spi_done` input 1: one-cycle completion from the SPI controller.
- `cs_n` output 1: panel chip-select, active-low, registered.
- `busy` output 1: FSM not in IDLE.
- `overflow` output 1: sticky; a write was dropped because FIFO was full.
- `timeout_err` output 1: sticky; watchdog fired.
- `err_clr` input 1: synchronous clear of `overflow` and `timeout_err`.

## Operation
- FIFO: circular buffer, 9-bit entries, read/write pointers `$clog2(DEPTH)` bits wrapping modulo DEPTH. `level` counter is separate from the pointers.
- Write rule: a write with `full`=1 is dropped and sets `overflow`. This holds even when a pop happens in the same cycle, because `full` is judged before the pop.
- Push and pop in the same cycle when not full: `level` unchanged, both pointers advance.
- Pop = latch head into `tx_byte`/`tx_dc` and advance the read pointer, in one edge. Pops happen only on FSM transitions into ISSUE.
- FSM states:
  - IDLE: `cs_n`=1. Moves to SETUP when `empty`=0.
  - SETUP: `cs_n`=0. Counts CS_SETUP cycles, then pops and moves to ISSUE.
  - ISSUE: `send`=1 for exactly one cycle, then WAIT.
  - WAIT: `send`=0, watchdog counting.
    - `spi_done` with FIFO non-empty: pop, then ISSUE (back-to-back).
    - `spi_done` with FIFO empty: HOLD.
    - Watchdog reaching TIMEOUT: set `timeout_err`, go to IDLE. FIFO contents are retained.
  - HOLD: `cs_n`=0, counting idle cycles.
    - FIFO becomes non-empty: pop, then ISSUE without re-running SETUP.
    - Count reaches CS_HOLD: go to IDLE, `cs_n`=1.
- `spi_done` outside WAIT is ignored.
- `tx_byte`/`tx_dc` change only on a pop and are otherwise held, including through IDLE.
- `err_clr` has priority over a same-cycle error set. Errors do not block further operation.
- Asynchronous reset mid-burst:
  - Immediately: `cs_n`=1, `send`=0, FSM to IDLE.
  - FIFO is emptied (pointers and `level` to 0).
  - Errors and `tx_*` cleared.

## Timing
- Reset values:
  - `send`=0, `cs_n`=1, `busy`=0.
  - `tx_byte`=8'h00, `tx_dc`=0.
  - `empty`=1, `full`=0, `level`=0.
  - `overflow`=0, `timeout_err`=0.
- FIFO flags and `level` update on the edge after the push or pop.
- Write sampled at edge N into an idle, empty block:
  - `cs_n` falls after edge N+1.
  - `send` is high in the cycle after edge N+1+CS_SETUP, with `tx_byte`/`tx_dc` already valid.
- `spi_done` sampled at edge M with FIFO non-empty: new `tx_*` and `send`=1 in the cycle after edge M. This matches the SPI controller returning to INIT on the same edge.
- Last `spi_done` at edge M with no further writes: `cs_n` rises after edge M+CS_HOLD+1.
- Watchdog: with no `spi_done`, `timeout_err`=1 and `cs_n`=1 after TIMEOUT cycles in WAIT.
- `busy`=1 from the edge leaving IDLE until the edge entering IDLE.

## Test plan
- Reset: assert `rst`=0 mid-WAIT with 3 entries queued -> `cs_n`=1, `send`=0, `level`=0, `empty`=1 immediately; no `send` after release.
- Single command: push {0, 8'h2A} into an idle block, defaults -> `cs_n` low 1 cycle later; `send` pulse 1 cycle after that with `tx_byte`=8'h2A, `tx_dc`=0; after the model's `done`, `cs_n` high 5 cycles later.
- Burst: push {0,8'h2C} then 5 pixel bytes {1,8'hF8..8'hFC} -> 6 `send` pulses, each one cycle after the prior `done`; `cs_n` continuously low; `tx_dc` 0 then 1; order preserved.
- Full/overflow: hold SPI model busy, push 17 entries with DEPTH=16 -> `full`=1 at 16, 17th dropped, `overflow`=1. Push and pop in the same cycle while full -> write dropped, `level`=15. `err_clr` -> `overflow`=0.
- HOLD re-entry: push one byte 2 cycles after its `done` (CS_HOLD=4) -> next `send` without `cs_n` rising and without the SETUP delay.
- Watchdog: never return `done` -> `timeout_err`=1 after 64 WAIT cycles, `cs_n`=1, remaining FIFO entries kept. Next `done` in IDLE is ignored, then the block re-issues normally.
